// File: rtl/sdspi_pkg.sv
// Shared types and constants for the SD SPI-mode command path (card and host side).
package sdspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_CHK,
        ST_NCR,
        ST_WAIT_RSP,
        ST_RESP,
        ST_BUSY
    } state_t;

    localparam logic [6:0] CRC7_POLY  = 7'h09;

    localparam logic [1:0] RSP_R1     = 2'b00;
    localparam logic [1:0] RSP_R1B    = 2'b01;
    localparam logic [1:0] RSP_R37    = 2'b10;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_CRC_ERR = 8'h08;

    localparam logic [7:0] START_MASK = 8'hC0;
    localparam logic [7:0] START_VAL  = 8'h40;

    // One byte of CRC7 advance, MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/sdcrc7.sv
// Bytewise CRC7 accumulator. i_clr together with i_stb restarts the sum at the given byte.
module sdcrc7
    import sdspi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clr,
    input  logic       i_stb,
    input  logic [7:0] i_byte,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_crc <= 7'd0;
        end else if (i_stb) begin
            r_crc <= crc7_byte(i_clr ? 7'd0 : r_crc, i_byte);
        end else if (i_clr) begin
            r_crc <= 7'd0;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/spirsp.sv
// SD-card-side SPI-mode command responder: frames commands, forwards them, returns R1/R1b/R3/R7.
// Optional build macro CRC_CHECK_EN enables CRC7/end-bit checking of incoming frames.
module spirsp
    import sdspi_pkg::*;
#(
    parameter int NCR_BYTES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sel,
    input  logic        i_ll_stb,
    input  logic [7:0]  i_ll_byte,
    output logic [7:0]  o_ll_byte,
    output logic        o_cmd_stb,
    output logic [5:0]  o_cmd,
    output logic [31:0] o_cmd_arg,
    output logic        o_crc_err,
    input  logic        i_rsp_stb,
    input  logic [1:0]  i_rsp_type,
    input  logic [7:0]  i_rsp_r1,
    input  logic [31:0] i_rsp_data,
    input  logic        i_card_busy,
    input  logic        i_idle,
    output logic        o_busy
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [5:0]  r_cmd;
    logic [31:0] r_arg;
    logic        r_have;
    logic [1:0]  r_rtype;
    logic [7:0]  r_r1;
    logic [31:0] r_data;
    logic [7:0]  r_ll_byte;

    logic        w_start;
    logic        w_crc_ok;
    logic        w_have;
    logic        w_take;
    logic [7:0]  w_r1;
    logic [7:0]  w_byte;

    assign w_start = i_ll_stb && ((i_ll_byte & START_MASK) == START_VAL);
    // A response arriving on the same cycle as the last gap exchange still makes that R1 slot.
    assign w_have  = r_have || i_rsp_stb;
    assign w_r1    = r_have ? r_r1 : i_rsp_r1;
    assign w_take  = i_rsp_stb && ((r_state == ST_NCR && !r_have) || r_state == ST_WAIT_RSP);

`ifdef CRC_CHECK_EN
    logic [7:0] r_crc_byte;
    logic [6:0] w_crc;
    logic       w_crc_clr;
    logic       w_crc_stb;

    assign w_crc_clr = i_sel && r_state == ST_IDLE && w_start;
    assign w_crc_stb = w_crc_clr || (i_sel && r_state == ST_CMD && i_ll_stb && r_cnt != 4'd4);

    sdcrc7 u_crc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_crc_clr),
        .i_stb   (w_crc_stb),
        .i_byte  (i_ll_byte),
        .o_crc   (w_crc)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_crc_byte <= 8'd0;
        end else if (r_state == ST_CMD && i_ll_stb && r_cnt == 4'd4) begin
            r_crc_byte <= i_ll_byte;
        end
    end

    assign w_crc_ok  = (w_crc == r_crc_byte[7:1]) && r_crc_byte[0];
    assign o_crc_err = i_sel && r_state == ST_CHK && !w_crc_ok;
`else
    assign w_crc_ok  = 1'b1;
    assign o_crc_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_start) w_next = ST_CMD;
            ST_CMD:      if (i_ll_stb && r_cnt == 4'd4) w_next = ST_CHK;
            ST_CHK:      w_next = ST_NCR;
            ST_NCR:      if (i_ll_stb && r_cnt <= 4'd1) w_next = w_have ? ST_RESP : ST_WAIT_RSP;
            ST_WAIT_RSP: if (i_rsp_stb) w_next = ST_RESP;
            ST_RESP: begin
                if (i_ll_stb) begin
                    if (r_cnt == 4'd1 && !r_rtype[1]) begin
                        w_next = (r_rtype == RSP_R1B && i_card_busy) ? ST_BUSY : ST_IDLE;
                    end else if (r_cnt == 4'd5) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_BUSY:     if (i_ll_stb && !i_card_busy) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
        if (!i_sel) w_next = ST_IDLE;
    end

    // r_cnt in RESP counts response bytes already loaded into the MISO register.
    always_comb begin
        w_byte = 8'hFF;
        case (r_state)
            ST_NCR: begin
                if (r_cnt <= 4'd1 && w_have) w_byte = w_r1;
            end
            ST_RESP: begin
                if (r_cnt == 4'd0) begin
                    w_byte = r_r1;
                end else if (r_rtype[1] && r_cnt <= 4'd4) begin
                    w_byte = r_data[31:24];
                end else if (r_cnt == 4'd1 && r_rtype == RSP_R1B && i_card_busy) begin
                    w_byte = 8'h00;
                end
            end
            ST_BUSY: begin
                if (i_card_busy) w_byte = 8'h00;
            end
            default: w_byte = 8'hFF;
        endcase
    end

    assign o_cmd_stb = i_sel && r_state == ST_CHK && w_crc_ok;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_ll_byte = r_ll_byte;
    assign o_cmd     = r_cmd;
    assign o_cmd_arg = r_arg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ll_byte <= 8'hFF;
            r_cnt     <= 4'd0;
            r_cmd     <= 6'd0;
            r_arg     <= 32'd0;
            r_have    <= 1'b0;
            r_rtype   <= RSP_R1;
            r_r1      <= 8'd0;
            r_data    <= 32'd0;
        end else if (!i_sel) begin
            r_ll_byte <= 8'hFF;
            r_cnt     <= 4'd0;
            r_have    <= 1'b0;
        end else begin
            if (i_ll_stb) r_ll_byte <= w_byte;
            if (w_take) begin
                r_have  <= 1'b1;
                r_rtype <= i_rsp_type;
                r_r1    <= i_rsp_r1;
                r_data  <= i_rsp_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cmd  <= i_ll_byte[5:0];
                        r_cnt  <= 4'd0;
                        r_have <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (i_ll_stb) begin
                        if (r_cnt != 4'd4) r_arg <= {r_arg[23:0], i_ll_byte};
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_CHK: begin
                    r_cnt <= 4'(NCR_BYTES);
                    if (!w_crc_ok) begin
                        r_have  <= 1'b1;
                        r_rtype <= RSP_R1;
                        r_r1    <= R1_CRC_ERR | (i_idle ? R1_IDLE : 8'h00);
                    end
                end
                ST_NCR: begin
                    if (i_ll_stb) r_cnt <= (r_cnt <= 4'd1 && w_have) ? 4'd1 : r_cnt - 4'd1;
                end
                ST_WAIT_RSP: begin
                    if (i_rsp_stb) r_cnt <= 4'd0;
                end
                ST_RESP: begin
                    if (i_ll_stb) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_rtype[1] && r_cnt != 4'd0 && r_cnt <= 4'd4) begin
                            r_data <= {r_data[23:0], 8'h00};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
